// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: STAGES registered ripple chunks, valid/ready at both ends.
// Define ADDSUB_SAT_EN to clamp the result to the signed range on overflow.
module pipelined_addsub #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned CW = WIDTH / STAGES;

    logic             stall;
    logic [WIDTH-1:0] res_n;
    logic [WIDTH-1:0] sum_n;
    logic             cout_n;
    logic             ovf_n;
    logic             vld_n;

    // Global enable: a held output freezes the whole pipeline.
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : stage
            // Operand bits still to be consumed when entering stage k.
            localparam int unsigned REM = WIDTH - k * CW;

            logic [REM-1:0] op_a;
            logic [REM-1:0] op_b;
            logic           cy_in;
            logic           vld_in;
            logic [CW:0]    part;

            if (k == 0) begin : g_first
                // Subtraction is folded into inverted B and inverted carry-in.
                assign op_a   = a;
                assign op_b   = b ^ {WIDTH{sub}};
                assign cy_in  = cin ^ sub;
                assign vld_in = in_valid;
            end else begin : g_next
                assign op_a   = stage[k-1].g_reg.a_q;
                assign op_b   = stage[k-1].g_reg.b_q;
                assign cy_in  = stage[k-1].g_reg.c_q;
                assign vld_in = stage[k-1].g_reg.v_q;
            end

            assign part = {1'b0, op_a[CW-1:0]} + {1'b0, op_b[CW-1:0]} + (CW+1)'(cy_in);

            if (k < STAGES - 1) begin : g_reg
                logic [REM-CW-1:0]   a_q;
                logic [REM-CW-1:0]   b_q;
                logic [(k+1)*CW-1:0] r_q;
                logic [(k+1)*CW-1:0] r_n;
                logic                c_q;
                logic                v_q;

                // Skew: upper operand chunks travel on; deskew: finished chunks accumulate below.
                if (k == 0) begin : g_r0
                    assign r_n = part[CW-1:0];
                end else begin : g_rk
                    assign r_n = {part[CW-1:0], stage[k-1].g_reg.r_q};
                end

                always_ff @(posedge clk) begin
                    if (rst) begin
                        a_q <= '0;
                        b_q <= '0;
                        r_q <= '0;
                        c_q <= 1'b0;
                        v_q <= 1'b0;
                    end else if (!stall) begin
                        a_q <= op_a[REM-1:CW];
                        b_q <= op_b[REM-1:CW];
                        r_q <= r_n;
                        c_q <= part[CW];
                        v_q <= vld_in;
                    end
                end
            end else begin : g_last
                if (k == 0) begin : g_r0
                    assign res_n = part[CW-1:0];
                end else begin : g_rk
                    assign res_n = {part[CW-1:0], stage[k-1].g_reg.r_q};
                end

                // Carry into the MSB is recovered from the MSB sum bit and its operands.
                assign cout_n = part[CW];
                assign ovf_n  = part[CW] ^ part[CW-1] ^ op_a[CW-1] ^ op_b[CW-1];
                assign vld_n  = vld_in;
            end
        end
    endgenerate

    // Final result selection; clamping happens ahead of the output register.
    always_comb begin
        sum_n = res_n;
`ifdef ADDSUB_SAT_EN
        if (ovf_n) begin
            sum_n = res_n[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
        end
`else
`endif
    end

    // The last stage register doubles as the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (!stall) begin
            out_valid <= vld_n;
            sum       <= sum_n;
            cout      <= cout_n;
            ovf       <= ovf_n;
            zero      <= (sum_n == '0);
        end
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed self-checking bench for pipelined_addsub (WIDTH=16, STAGES=4).
module tb_pipelined_addsub;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned STAGES = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipelined_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // One beat into an empty pipeline; checks latency and all result flags.
    task automatic send_one(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                            input logic tcin, input logic tsub, input logic [15:0] esum,
                            input logic ecout, input logic eovf, input logic ezero);
        int lat;
        @(posedge clk); #1;
        a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd4);
        check({tag, "_sum"}, 32'(sum), 32'(esum));
        check({tag, "_cout"}, 32'(cout), 32'(ecout));
        check({tag, "_ovf"}, 32'(ovf), 32'(eovf));
        check({tag, "_zero"}, 32'(zero), 32'(ezero));
    endtask

    initial begin
        logic [15:0] held_sum;
        logic [15:0] exp_ovf_sum;
        logic [15:0] exp_neg_sum;
        int          sent;
        int          got;
        int          stall_left;
        int          cyc;
        bit          stalled_once;
        bit          held;
        bit          acc;
        bit          fire;

`ifdef ADDSUB_SAT_EN
        exp_ovf_sum = 16'h7FFF;
        exp_neg_sum = 16'h8000;
`else
        exp_ovf_sum = 16'h8000;
        exp_neg_sum = 16'h7FFF;
`endif

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_vld", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_flags", {29'd0, cout, ovf, zero}, 32'd0);
        check("rst_rdy", 32'(in_ready), 32'd1);

        send_one("add_carry8", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
        send_one("add_wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        send_one("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, exp_ovf_sum, 1'b0, 1'b1, 1'b0);
        send_one("sub_neg",    16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        send_one("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0, 1'b0);
        send_one("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, exp_neg_sum, 1'b1, 1'b1, 1'b0);
        send_one("sub_zero",   16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);

        // Back-to-back stream with a 3-cycle downstream stall on the first result.
        sent = 0; got = 0; stall_left = 0; cyc = 0;
        stalled_once = 1'b0; held = 1'b0; held_sum = '0;
        @(posedge clk); #1;
        while (got < 8 && cyc < 100) begin
            if (out_valid && !stalled_once) begin
                stalled_once = 1'b1;
                stall_left = 3;
            end
            out_ready = (stall_left == 0);
            in_valid = (sent < 8);
            a = 16'(sent); b = 16'h1000; cin = 1'b0; sub = 1'b0;
            #1;
            if (held) begin
                check("hold_vld", 32'(out_valid), 32'd1);
                check("hold_sum", 32'(sum), 32'(held_sum));
            end
            if (stall_left > 0) begin
                check("stall_rdy", 32'(in_ready), 32'd0);
                stall_left--;
            end
            held = out_valid && !out_ready;
            held_sum = sum;
            acc = in_valid && in_ready;
            fire = out_valid && out_ready;
            if (fire) begin
                check("stream_sum", 32'(sum), 32'h1000 + 32'(got));
                got++;
            end
            @(posedge clk); #1;
            if (acc) sent++;
            cyc++;
        end
        check("stream_cnt", 32'(got), 32'd8);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);

        // Reset with three beats in flight: nothing stale may come out.
        #1;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1; a = 16'(i); b = 16'h0010; cin = 1'b0; sub = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("post_rst_vld", 32'(out_valid), 32'd0);
            @(posedge clk); #1;
        end
        send_one("after_rst", 16'h1234, 16'h0001, 1'b0, 1'b0, 16'h1235, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
Parametrised, pipelined adder/subtractor; the next generation of the team's 4-bit ripple-carry adder. The WIDTH-bit operation is split into STAGES equal chunks, each resolved in its own registered ripple stage with the carry passed stage to stage. The block has a valid/ready handshake at both ends and reports carry, signed overflow and zero. It is the arithmetic back end for datapath blocks that need more than 4 bits at higher clock rates.

Parameters:
WIDTH, 16, operand and result width in bits; must be a multiple of STAGES.
STAGES, 4, number of pipeline stages (1..WIDTH); chunk width CW = WIDTH/STAGES.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  operand beat present.
in_ready  output  1  block accepts a beat this cycle.
a  input  WIDTH  operand A, unsigned or two's complement.
b  input  WIDTH  operand B.
cin  input  1  carry-in (add) or borrow-in (sub).
sub  input  1  0 = add, 1 = subtract.
out_valid  output  1  result beat present.
out_ready  input  1  downstream accepts the result.
sum  output  WIDTH  result.
cout  output  1  add: carry-out; sub: 1 = no borrow.
ovf  output  1  signed overflow.
zero  output  1  sum == 0.

Behaviour:
- One clock domain. Reset is synchronous and active-high, as already decided.
- Reset: all stage valid bits clear; out_valid=0, sum=0, cout=0, ovf=0, zero=0. in_ready=1 in the first cycle after reset.
- Function:
  - sub=0: result = a + b + cin.
  - sub=1: result = a + ~b + !cin, i.e. a - b - cin.
  - Result is computed modulo 2^WIDTH. cout is bit WIDTH of the extended sum.
- ovf = carry into MSB XOR carry out of MSB. zero is computed from the final registered sum.
- Stage k (0..STAGES-1) adds chunk k, bits [k*CW +: CW], using the carry registered by stage k-1 (stage 0 uses the effective carry-in).
  - Higher-order operand chunks are delayed in skew registers.
  - Finished lower chunks are delayed in deskew registers so all bits of one beat emerge together.
- Latency: exactly STAGES cycles from acceptance (in_valid && in_ready) to out_valid with no stall. Throughput is one beat per cycle.
- Stall: stall = out_valid && !out_ready.
  - in_ready = !stall.
  - While stalled, every stage register, including valid bits, holds its value.
  - Bubbles are not compressed; this is a simple global-enable pipeline.
- in_ready does not depend on in_valid. No combinational path from in_valid to in_ready.
- Beats with in_valid=0 propagate as bubbles; sum/cout/ovf/zero are don't-care while out_valid=0.
- Ordering is strictly FIFO. No beat is dropped or duplicated under any out_ready pattern.
- out_valid, once asserted, stays high with sum/cout/ovf/zero stable until out_ready is sampled high.
- Reset mid-operation: all in-flight beats are discarded; out_valid drops the cycle after rst is sampled.
- STAGES=1: a single registered full-width ripple adder, latency 1. STAGES=WIDTH: one bit per stage.

Optional Feature:
ADDSUB_SAT_EN
- Defined: when ovf=1 in the final stage, sum is clamped to 0x7FF..F (positive overflow) or 0x80..0 (negative overflow). ovf still reports 1; cout is unchanged; zero reflects the clamped value. Clamping adds no latency.
- Not defined: sum wraps modulo 2^WIDTH, and no saturation logic is present.

Test Plan:
All cases use WIDTH=16, STAGES=4, out_ready=1 unless stated.
- a=0x00FF, b=0x0001, cin=0, sub=0 -> 4 cycles after accept: sum=0x0100, cout=0, ovf=0, zero=0.
- a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, ovf=0, zero=1. Same with ADDSUB_SAT_EN -> identical result.
- a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, ovf=1. With ADDSUB_SAT_EN -> sum=0x7FFF, ovf=1.
- a=0x0005, b=0x0007, cin=0, sub=1 -> sum=0xFFFE, cout=0. Then cin=1 -> sum=0xFFFD.
- Stream of 8 back-to-back beats a=i, b=0x1000, with out_ready low for 3 cycles once the first result appears:
  - in_ready=0 during the stall;
  - all 8 results 0x1000+i appear in order, none lost;
  - out_valid and sum are held stable while out_ready=0.
- Accept 3 beats, assert rst for 1 cycle -> out_valid=0 the next cycle and stays 0. No stale results appear; a new beat after reset emerges with latency 4.
